// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier (low N bits of a*b) that sequences a single
// shared ALU through OR/ADD/SLL/SRL, one operation per cycle.

module alu #(
  parameter int N = 32
) (
  input  logic [3:0]   control,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         overflow
);
  localparam int SHW = $clog2(N);

  // overflow reports the unsigned carry-out of ADD and is 0 for every other op
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      4'b0000: result = a & b;
      4'b0010: result = a | b;
      4'b1000: {overflow, result} = {1'b0, a} + {1'b0, b};
      4'b0101: result = a << b[SHW-1:0];
      4'b0110: result = a >> b[SHW-1:0];
      default: result = '0;
    endcase
    zero = (result == '0);
  end
endmodule

module alu_mul_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] product,
  output logic         overflow,
  output logic         busy
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] TEST = 3'd1;
  localparam logic [2:0] ADD  = 3'd2;
  localparam logic [2:0] SHL  = 3'd3;
  localparam logic [2:0] SHR  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [2:0]   state;
  logic [N-1:0] acc;
  logic [N-1:0] mcand;
  logic [N-1:0] mplier;
  logic         ovf;

  logic [3:0]   alu_control;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_result;
  logic         alu_zero;
  logic         alu_overflow;

  alu #(.N(N)) u_alu (
    .control  (alu_control),
    .a        (alu_a),
    .b        (alu_b),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  // In IDLE/DONE the ALU idles on ADD acc+mcand; its result is ignored there
  always_comb begin
    alu_control = OP_ADD;
    alu_a       = acc;
    alu_b       = mcand;
    case (state)
      TEST: begin
        alu_control = OP_OR;
        alu_a       = mplier;
        alu_b       = '0;
      end
      SHL: begin
        alu_control = OP_SLL;
        alu_a       = mcand;
        alu_b       = ONE;
      end
      SHR: begin
        alu_control = OP_SRL;
        alu_a       = mplier;
        alu_b       = ONE;
      end
      default: ;
    endcase
  end

  // A bit shifted out of mcand only matters if a higher multiplier bit would still add it
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            ovf    <= 1'b0;
            state  <= TEST;
          end
        end
        TEST: begin
          if (alu_zero)       state <= DONE;
          else if (mplier[0]) state <= ADD;
          else                state <= SHL;
        end
        ADD: begin
          acc   <= alu_result;
          ovf   <= ovf | alu_overflow;
          state <= SHL;
        end
        SHL: begin
          mcand <= alu_result;
          ovf   <= ovf | (mcand[N-1] & (|mplier[N-1:1]));
          state <= SHR;
        end
        SHR: begin
          mplier <= alu_result;
          state  <= TEST;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == TEST) | (state == ADD) | (state == SHL) | (state == SHR);
  assign product   = acc;
  assign overflow  = ovf;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized and directed bench for alu_mul_sequencer against a 64-bit
// arithmetic reference model and a closed-form latency formula.

module tb_alu_mul_sequencer;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_mul_sequencer #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Busy cycles: one TEST per examined bit plus a final TEST, one SHL+SHR per bit, one ADD per set bit
  function automatic int modelLatency(input logic [31:0] op_b);
    int k;
    int p;
    k = 0;
    p = 0;
    if (op_b == 32'd0) return 1;
    for (int i = 0; i < 32; i++) begin
      if (op_b[i]) begin
        k = i;
        p++;
      end
    end
    return 3 * k + 4 + p;
  endfunction

  task automatic applyStimulus(input logic [31:0] op_a, input logic [31:0] op_b,
                               input int stall, input bit pulse_mid);
    logic [63:0] full;
    logic [31:0] exp_p;
    logic        exp_o;
    int          cnt;
    full  = {32'd0, op_a} * {32'd0, op_b};
    exp_p = full[31:0];
    exp_o = |full[63:32];

    cnt = 0;
    while (!in_ready && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("in_ready_idle", 64'(in_ready), 64'd1);

    a = op_a;
    b = op_b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;

    cnt = 0;
    while (busy && cnt < 200) begin
      if (pulse_mid && cnt == 3) begin
        in_valid = 1'b1;
        a = 32'h0000_DEAD;
        b = 32'h0000_0055;
      end else begin
        in_valid = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;

    checkOutput("latency", 64'(cnt), 64'(modelLatency(op_b)));
    checkOutput("out_valid_done", 64'(out_valid), 64'd1);
    checkOutput("product", 64'(product), 64'(exp_p));
    checkOutput("overflow", 64'(overflow), 64'(exp_o));
    checkOutput("in_ready_done", 64'(in_ready), 64'd0);

    out_ready = 1'b0;
    repeat (stall) @(negedge clk);
    if (stall > 0) begin
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_product", 64'(product), 64'(exp_p));
      checkOutput("stall_overflow", 64'(overflow), 64'(exp_o));
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    end

    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("in_ready_after", 64'(in_ready), 64'd1);
    checkOutput("out_valid_after", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int cnt;
    logic [31:0] ra;
    logic [31:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_product", 64'(product), 64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);

    applyStimulus(32'd7, 32'd3, 0, 1'b0);
    applyStimulus(32'h1234_5678, 32'd0, 0, 1'b0);
    applyStimulus(32'd0, 32'hFFFF_FFFF, 0, 1'b0);
    applyStimulus(32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd2, 0, 1'b0);
    applyStimulus(32'd7, 32'd3, 20, 1'b0);
    applyStimulus(32'h0000_1234, 32'h0000_000F, 0, 1'b1);

    // Abort a=9, b=0xFF on its 5th busy cycle
    cnt = 0;
    while (!in_ready && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    a = 32'd9;
    b = 32'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_product", 64'(product), 64'd0);
    checkOutput("abort_overflow", 64'(overflow), 64'd0);
    applyStimulus(32'd6, 32'd5, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      applyStimulus(ra, rb, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
